// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse letter sequencer.
// Contents: FSM state enum, handshake field widths, default unit counts and a
// helper that clamps the requested element count to the supported maximum.
package morse_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StMark,
        StSpace,
        StLgap
    } state_t;

    localparam int unsigned MCODE_W = 4;
    localparam int unsigned MLEN_W  = 3;
    localparam int unsigned IDX_W   = 3;
    // Unit counter holds up to 3 units; widen if dash/gap lengths grow past that.
    localparam int unsigned UNIT_W  = 2;

    localparam int unsigned DEF_UNIT_CYCLES      = 12500000;
    localparam int unsigned DEF_DASH_UNITS       = 3;
    localparam int unsigned DEF_LETTER_GAP_UNITS = 3;
    localparam int unsigned DEF_MAX_LEN          = 4;

    function automatic logic [MLEN_W-1:0] clamp_len(input logic [MLEN_W-1:0] len,
                                                    input int unsigned      max_len);
        if (32'(len) > max_len) begin
            return MLEN_W'(max_len);
        end
        return len;
    endfunction

endpackage

// File: rtl/morse_sequencer_if.sv
// Letter handshake and blink-output bundle between a letter source and the
// sequencer.
//   mcode/mlength/valid/abort : source -> sequencer
//   ready/busy/done            : sequencer handshake status
//   led/shortbl/longbl         : lamp drives
interface morse_sequencer_if;
    import morse_pkg::*;

    logic [MCODE_W-1:0] mcode;
    logic [MLEN_W-1:0]  mlength;
    logic               valid;
    logic               ready;
    logic               abort;
    logic               led;
    logic               shortbl;
    logic               longbl;
    logic               busy;
    logic               done;

    modport master (
        output mcode, mlength, valid, abort,
        input  ready, led, shortbl, longbl, busy, done
    );

    modport slave (
        input  mcode, mlength, valid, abort,
        output ready, led, shortbl, longbl, busy, done
    );

endinterface

// File: rtl/morse_unit_timer.sv
// Interval timer counting whole Morse units of UNIT_CYCLES clocks each.
//   clk_i, rst_ni : clock, async active-low reset
//   start_i       : hold/restart; counters are zero on the cycle after it is high
//   units_i       : interval length in units (>= 1)
//   expire_o      : high on the final cycle of the interval
module morse_unit_timer
    import morse_pkg::*;
#(
    parameter int unsigned UNIT_CYCLES = DEF_UNIT_CYCLES
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [UNIT_W-1:0] units_i,
    output logic              expire_o
);

    localparam int unsigned       PrescW    = $clog2(UNIT_CYCLES + 1);
    localparam logic [PrescW-1:0] PrescLast = PrescW'(UNIT_CYCLES - 1);

    logic [PrescW-1:0] presc_q, presc_d;
    logic [UNIT_W-1:0] unit_q, unit_d;
    logic              unit_tick;

    assign unit_tick = (presc_q == PrescLast);
    assign expire_o  = unit_tick && (unit_q == (units_i - UNIT_W'(1)));

    always_comb begin
        presc_d = presc_q;
        unit_d  = unit_q;
        if (start_i) begin
            presc_d = '0;
            unit_d  = '0;
        end else if (unit_tick) begin
            presc_d = '0;
            unit_d  = unit_q + UNIT_W'(1);
        end else begin
            presc_d = presc_q + PrescW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc_q <= '0;
            unit_q  <= '0;
        end else begin
            presc_q <= presc_d;
            unit_q  <= unit_d;
        end
    end

endmodule

// File: rtl/morse_sequencer.sv
// Plays one Morse letter at a time on the lamp outputs.
//   clk     : system clock
//   reset_n : async active-low reset (released synchronously inside)
//   io      : slave side of the letter handshake / lamp bundle
// A letter (mcode bit 0 first, 1 = dash) is taken when valid && ready; each
// mark is followed by a one-unit space, the last by the letter gap, then done
// pulses for one cycle in IDLE.
module morse_sequencer
    import morse_pkg::*;
#(
    parameter int unsigned UNIT_CYCLES      = DEF_UNIT_CYCLES,
    parameter int unsigned DASH_UNITS       = DEF_DASH_UNITS,
    parameter int unsigned LETTER_GAP_UNITS = DEF_LETTER_GAP_UNITS,
    parameter int unsigned MAX_LEN          = DEF_MAX_LEN
) (
    input logic               clk,
    input logic               reset_n,
    morse_sequencer_if.slave  io
);

    logic [1:0]         rst_sync_q;
    logic               rst_n_int;
    state_t             state_q;
    logic [MCODE_W-1:0] sreg_q;
    logic [MLEN_W-1:0]  len_q;
    logic [IDX_W-1:0]   idx_q;
    logic               ready_q, led_q, short_q, long_q, done_q;
    logic [MLEN_W-1:0]  len_in;
    logic [UNIT_W-1:0]  units;
    logic               tmr_start, expire;

    // Assert asynchronously, release two clocks after reset_n rises.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end
    assign rst_n_int = rst_sync_q[1];

    assign len_in = clamp_len(io.mlength, MAX_LEN);

    always_comb begin
        unique case (state_q)
            StMark:  units = sreg_q[0] ? UNIT_W'(DASH_UNITS) : UNIT_W'(1);
            StLgap:  units = UNIT_W'(LETTER_GAP_UNITS);
            default: units = UNIT_W'(1);
        endcase
    end

    // Timer is held clear in IDLE and restarted on every transition, so each
    // state begins with zeroed counters.
    assign tmr_start = (state_q == StIdle) || expire || io.abort;

    morse_unit_timer #(
        .UNIT_CYCLES (UNIT_CYCLES)
    ) u_timer (
        .clk_i    (clk),
        .rst_ni   (rst_n_int),
        .start_i  (tmr_start),
        .units_i  (units),
        .expire_o (expire)
    );

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q <= StIdle;
            sreg_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            ready_q <= 1'b1;
            led_q   <= 1'b0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q != StIdle && io.abort) begin
                state_q <= StIdle;
                ready_q <= 1'b1;
                led_q   <= 1'b0;
                short_q <= 1'b0;
                long_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (io.valid) begin
                            sreg_q  <= io.mcode;
                            len_q   <= len_in;
                            idx_q   <= '0;
                            ready_q <= 1'b0;
                            if (len_in != '0) begin
                                state_q <= StMark;
                                led_q   <= 1'b1;
                                short_q <= ~io.mcode[0];
                                long_q  <= io.mcode[0];
                            end else begin
                                state_q <= StLgap;
                            end
                        end
                    end
                    StMark: begin
                        if (expire) begin
                            led_q   <= 1'b0;
                            short_q <= 1'b0;
                            long_q  <= 1'b0;
                            if ((idx_q + IDX_W'(1)) < len_q) begin
                                sreg_q  <= sreg_q >> 1;
                                idx_q   <= idx_q + IDX_W'(1);
                                state_q <= StSpace;
                            end else begin
                                state_q <= StLgap;
                            end
                        end
                    end
                    StSpace: begin
                        if (expire) begin
                            state_q <= StMark;
                            led_q   <= 1'b1;
                            short_q <= ~sreg_q[0];
                            long_q  <= sreg_q[0];
                        end
                    end
                    StLgap: begin
                        if (expire) begin
                            state_q <= StIdle;
                            ready_q <= 1'b1;
                            done_q  <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign io.ready   = ready_q;
    assign io.busy    = ~ready_q;
    assign io.led     = led_q;
    assign io.shortbl = short_q;
    assign io.longbl  = long_q;
    assign io.done    = done_q;

endmodule

// File: tb/tb_morse_sequencer.sv
// Bench for morse_sequencer: a cycle-level letter model expands each accepted
// letter into its expected lamp trace; every cycle's expected output vector is
// queued and a monitor compares it with the DUT half a clock later.
module tb_morse_sequencer;

    localparam int unsigned U      = 2;
    localparam int unsigned DASH   = 3;
    localparam int unsigned GAP    = 3;
    localparam int unsigned MAXLEN = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    morse_sequencer_if io ();

    morse_sequencer #(
        .UNIT_CYCLES      (U),
        .DASH_UNITS       (DASH),
        .LETTER_GAP_UNITS (GAP),
        .MAX_LEN          (MAXLEN)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .io      (io.slave)
    );

    int total = 0;
    int bad   = 0;

    // Expected {ready, busy, led, shortbl, longbl, done} per cycle.
    logic [5:0] sb[$];
    // Remaining busy cycles of the current letter as {led, shortbl, longbl}.
    logic [2:0] busyq[$];
    logic       done_next = 1'b0;

    task automatic check(input string name, input logic [5:0] got, input logic [5:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%b want=%b (r,b,led,s,l,done) t=%0t", name, got, want, $time);
        end
    endtask

    function automatic logic [5:0] dut_vec();
        return {io.ready, io.busy, io.led, io.shortbl, io.longbl, io.done};
    endfunction

    // Monitor: compare whatever expectation was queued for this cycle.
    initial begin
        logic [5:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("cycle_out", dut_vec(), e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    task automatic expand_letter(input logic [3:0] mc, input logic [2:0] ml);
        int n;
        n = (int'(ml) > MAXLEN) ? MAXLEN : int'(ml);
        for (int i = 0; i < n; i++) begin
            int mark_units;
            mark_units = mc[i] ? DASH : 1;
            repeat (mark_units * U) busyq.push_back({1'b1, ~mc[i], mc[i]});
            if (i < n - 1) repeat (U) busyq.push_back(3'b000);
        end
        repeat (GAP * U) busyq.push_back(3'b000);
    endtask

    // One clock of stimulus: queue this cycle's expectation, drive inputs,
    // and advance the model to the next cycle.
    task automatic cycle(input logic v, input logic [3:0] mc, input logic [2:0] ml,
                         input logic ab);
        logic [5:0] e;
        logic       was_busy;
        @(negedge clk);
        if (busyq.size() > 0) begin
            e = {2'b01, busyq.pop_front(), 1'b0};
            was_busy = 1'b1;
        end else begin
            e = {5'b10000, done_next};
            done_next = 1'b0;
            was_busy = 1'b0;
        end
        sb.push_back(e);
        io.valid   = v;
        io.mcode   = mc;
        io.mlength = ml;
        io.abort   = ab;
        if (!was_busy && v) begin
            expand_letter(mc, ml);
        end else if (was_busy && ab) begin
            busyq.delete();
        end else if (was_busy && busyq.size() == 0) begin
            done_next = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 4'($urandom), 3'($urandom), 1'b0);
    endtask

    initial begin
        io.valid   = 1'b0;
        io.mcode   = '0;
        io.mlength = '0;
        io.abort   = 1'b0;

        // Reset held three cycles.
        repeat (3) begin
            @(negedge clk);
            #1;
            check("reset_state", dut_vec(), 6'b100000);
        end
        @(negedge clk);
        reset_n = 1'b1;
        idle(4);

        // 'A': dot, space, dash, gap, done at cycle 17.
        cycle(1'b1, 4'b0010, 3'd2, 1'b0);
        idle(20);

        // Zero length: gap only, done at cycle 7.
        cycle(1'b1, 4'b1011, 3'd0, 1'b0);
        idle(10);

        // Length 7 clamps to four dashes, done at cycle 37.
        cycle(1'b1, 4'b1111, 3'd7, 1'b0);
        idle(40);

        // Back-to-back 'E' with valid held high.
        repeat (25) cycle(1'b1, 4'b0000, 3'd1, 1'b0);
        idle(10);

        // Abort during the dash of 'A' at cycle 6.
        cycle(1'b1, 4'b0010, 3'd2, 1'b0);
        idle(5);
        cycle(1'b0, 4'b0010, 3'd2, 1'b1);
        idle(10);

        // Abort together with valid in IDLE: transfer wins.
        cycle(1'b1, 4'b0000, 3'd1, 1'b1);
        idle(12);

        // Randomised traffic with mid-letter input churn and sporadic aborts.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 99) < 40), 4'($urandom), 3'($urandom),
                  ($urandom_range(0, 99) < 3));
        end
        idle(45);

        // Reset in the middle of a dash mark.
        cycle(1'b1, 4'b0001, 3'd1, 1'b0);
        idle(3);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_drop", dut_vec(), 6'b100000);
        busyq.delete();
        done_next = 1'b0;
        io.valid  = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
            check("reset_hold", dut_vec(), 6'b100000);
        end
        @(negedge clk);
        reset_n = 1'b1;
        idle(6);

        for (int i = 0; i < 200; i++) begin
            cycle(($urandom_range(0, 99) < 50), 4'($urandom), 3'($urandom),
                  ($urandom_range(0, 99) < 2));
        end
        idle(45);

        repeat (2) @(negedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
